// File: rtl/miriscv_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : miriscv_mem_arb_pkg
// Brief    : Shared types for the instruction/data memory arbiter: FSM state,
//            port identifiers, pending-request record and arbitration helper.
// Revision : 1.0 - initial release
// ============================================================================
package miriscv_mem_arb_pkg;

  // Widest address any arbiter instance may use; narrower instances use the
  // low ADDR_W bits of the request record.
  localparam int unsigned c_ADDR_W_MAX = 64;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } arb_port_e;

  typedef struct packed {
    logic                    we;
    logic [3:0]              be;
    logic [c_ADDR_W_MAX-1:0] addr;
    logic [31:0]             wdata;
  } arb_req_t;

  // A lone pending port wins; on a tie the port that was not served last wins.
  function automatic arb_port_e arb_pick(input logic instr_v, input logic data_v,
                                         input arb_port_e last);
    if (instr_v && !data_v) return PORT_INSTR;
    if (data_v && !instr_v) return PORT_DATA;
    return (last == PORT_INSTR) ? PORT_DATA : PORT_INSTR;
  endfunction

endpackage
`default_nettype wire

// File: rtl/miriscv_mem_arb_slot.sv
`default_nettype none
// ============================================================================
// Module   : miriscv_mem_arb_slot
// Brief    : One pending-request register with its valid flag. Clear has
//            priority over load; the caller only loads into a free slot.
// Revision : 1.0 - initial release
// ============================================================================
module miriscv_mem_arb_slot
  import miriscv_mem_arb_pkg::*;
(
  input  logic     clk_i,
  input  logic     arstn_i,
  input  logic     load_i,
  input  logic     clear_i,
  input  arb_req_t req_i,
  output logic     valid_o,
  output arb_req_t req_o
);

  logic     r_valid;
  arb_req_t r_req;

  // Capture a request into the free slot, or release it when served/dropped.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_valid <= 1'b0;
      r_req   <= '0;
    end else if (clear_i) begin
      r_valid <= 1'b0;
    end else if (load_i) begin
      r_valid <= 1'b1;
      r_req   <= req_i;
    end
  end

  assign valid_o = r_valid;
  assign req_o   = r_req;

endmodule
`default_nettype wire

// File: rtl/miriscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : miriscv_mem_arbiter
// Brief    : Arbitrates the core's fetch and load/store ports onto a single
//            req/gnt/rvalid memory port, one outstanding transaction at a
//            time, with a sticky protocol/timeout error flag.
// Revision : 1.0 - initial release
// ============================================================================
module miriscv_mem_arbiter
  import miriscv_mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int MEM_TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  // fetch port
  input  logic              instr_req_i,
  input  logic [ADDR_W-1:0] instr_addr_i,
  output logic              instr_rvalid_o,
  output logic [31:0]       instr_rdata_o,
  // load/store port
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [31:0]       data_wdata_i,
  output logic              data_rvalid_o,
  output logic [31:0]       data_rdata_o,
  // shared memory port
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              err_o
);

  localparam int unsigned              c_TIMER_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_TIMER_W-1:0]     c_TIMER_LAST = c_TIMER_W'(MEM_TIMEOUT - 1);

  // Slot index 0 is the fetch port, index 1 the load/store port.
  logic [1:0]           w_slot_load;
  logic [1:0]           w_slot_clear;
  logic [1:0]           w_slot_valid;
  arb_req_t             w_slot_din  [2];
  arb_req_t             w_slot_dout [2];

  arb_state_e           r_state;
  arb_state_e           w_state_nxt;
  logic [c_TIMER_W-1:0] r_timer;
  arb_port_e            r_owner;
  arb_port_e            r_last;

  logic                 r_mem_req;
  logic                 r_mem_we;
  logic [3:0]           r_mem_be;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [31:0]          r_mem_wdata;
  logic                 r_instr_rvalid;
  logic [31:0]          r_instr_rdata;
  logic                 r_data_rvalid;
  logic [31:0]          r_data_rdata;
  logic                 r_err;

  logic                 w_progress;
  logic                 w_drop;
  arb_port_e            w_grant;
  arb_req_t             w_sel_req;
  logic                 w_issue;
  logic                 w_done;
  logic                 w_err_set;

  // Build slot inputs; fetches are stored already shaped as full-word reads.
  always_comb begin
    w_slot_din[0]                   = '0;
    w_slot_din[0].be                = 4'hF;
    w_slot_din[0].addr[ADDR_W-1:0]  = instr_addr_i;
    w_slot_din[1]                   = '0;
    w_slot_din[1].we                = data_we_i;
    w_slot_din[1].be                = data_be_i;
    w_slot_din[1].addr[ADDR_W-1:0]  = data_addr_i;
    w_slot_din[1].wdata             = data_wdata_i;
  end

  assign w_slot_load[0] = instr_req_i && !w_slot_valid[0];
  assign w_slot_load[1] = data_req_i  && !w_slot_valid[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      miriscv_mem_arb_slot u_slot (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .load_i  (w_slot_load[gi]),
        .clear_i (w_slot_clear[gi]),
        .req_i   (w_slot_din[gi]),
        .valid_o (w_slot_valid[gi]),
        .req_o   (w_slot_dout[gi])
      );
    end
  endgenerate

  // Record bits above ADDR_W are always zero and intentionally unused.
  generate
    if (ADDR_W < c_ADDR_W_MAX) begin : g_addr_pad
      logic w_unused_addr;
      assign w_unused_addr = ^{w_slot_dout[0].addr[c_ADDR_W_MAX-1:ADDR_W],
                               w_slot_dout[1].addr[c_ADDR_W_MAX-1:ADDR_W]};
    end
  endgenerate

  // A busy state makes progress on a grant (ISSUE) or a response (WAIT_RESP);
  // otherwise it is abandoned once the timer reaches its last count.
  assign w_progress = ((r_state == ST_ISSUE) && r_mem_req && mem_gnt_i) ||
                      ((r_state == ST_WAIT_RESP) && mem_rvalid_i);
  assign w_drop     = (r_state != ST_IDLE) && !w_progress && (r_timer == c_TIMER_LAST);

  // State register.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (|w_slot_valid) w_state_nxt = ST_ISSUE;
      ST_ISSUE:     if (w_progress) w_state_nxt = ST_WAIT_RESP;
                    else if (w_drop) w_state_nxt = ST_IDLE;
      ST_WAIT_RESP: if (w_progress || w_drop) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: grant selection, slot release and error detection.
  always_comb begin
    w_grant      = arb_pick(w_slot_valid[0], w_slot_valid[1], r_last);
    w_sel_req    = (w_grant == PORT_DATA) ? w_slot_dout[1] : w_slot_dout[0];
    w_issue      = (r_state == ST_IDLE) && (|w_slot_valid);
    w_done       = (r_state == ST_WAIT_RESP) && mem_rvalid_i;
    w_slot_clear = 2'b00;
    if (w_done || w_drop) begin
      if (r_owner == PORT_DATA) w_slot_clear[1] = 1'b1;
      else                      w_slot_clear[0] = 1'b1;
    end
    w_err_set    = (instr_req_i && w_slot_valid[0]) ||
                   (data_req_i  && w_slot_valid[1]) ||
                   (mem_rvalid_i && (r_state != ST_WAIT_RESP)) ||
                   w_drop;
  end

  // Busy-cycle timer, restarted on every state change.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i)                                          r_timer <= '0;
    else if ((r_state == ST_IDLE) || w_progress || w_drop) r_timer <= '0;
    else                                                   r_timer <= r_timer + 1'b1;
  end

  // Registered memory request, owner tracking, responses and sticky error.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_be       <= 4'h0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= 32'h0;
      r_owner        <= PORT_INSTR;
      r_last         <= PORT_INSTR;
      r_instr_rvalid <= 1'b0;
      r_instr_rdata  <= 32'h0;
      r_data_rvalid  <= 1'b0;
      r_data_rdata   <= 32'h0;
      r_err          <= 1'b0;
    end else begin
      r_instr_rvalid <= w_done && (r_owner == PORT_INSTR);
      r_data_rvalid  <= w_done && (r_owner == PORT_DATA);
      if (w_done && (r_owner == PORT_INSTR))              r_instr_rdata <= mem_rdata_i;
      if (w_done && (r_owner == PORT_DATA) && !r_mem_we) r_data_rdata  <= mem_rdata_i;
      if (w_issue) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= w_sel_req.we;
        r_mem_be    <= w_sel_req.be;
        r_mem_addr  <= w_sel_req.addr[ADDR_W-1:0];
        r_mem_wdata <= w_sel_req.wdata;
        r_owner     <= w_grant;
        r_last      <= w_grant;
      end else if ((r_state == ST_ISSUE) && (w_progress || w_drop)) begin
        r_mem_req   <= 1'b0;
      end
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign mem_req_o      = r_mem_req;
  assign mem_we_o       = r_mem_we;
  assign mem_be_o       = r_mem_be;
  assign mem_addr_o     = r_mem_addr;
  assign mem_wdata_o    = r_mem_wdata;
  assign instr_rvalid_o = r_instr_rvalid;
  assign instr_rdata_o  = r_instr_rdata;
  assign data_rvalid_o  = r_data_rvalid;
  assign data_rdata_o   = r_data_rdata;
  assign err_o          = r_err;

endmodule
`default_nettype wire

// File: doc/miriscv_mem_arbiter.md
MIRISCV_MEM_ARBITER -- requirements
Module: miriscv_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of all ports.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 1024, maximum cycles to wait for mem_gnt_i or mem_rvalid_i before flagging an error.
REQ-003 clk_i  in  1  single clock, all state on rising edge.
REQ-004 arstn_i  in  1  asynchronous, active-low reset.
REQ-005 instr_req_i / instr_addr_i  in  1 / ADDR_W  core fetch request and its address.
REQ-006 instr_rvalid_o / instr_rdata_o  out  1 / 32  fetch response pulse and its data.
REQ-007 data_req_i / data_we_i / data_be_i / data_addr_i / data_wdata_i  in  1 / 1 / 4 / ADDR_W / 32  core load/store request.
REQ-008 data_rvalid_o / data_rdata_o  out  1 / 32  load/store response pulse and load data.
REQ-009 mem_req_o / mem_we_o / mem_be_o / mem_addr_o / mem_wdata_o  out  1 / 1 / 4 / ADDR_W / 32  single shared memory request.
REQ-010 mem_gnt_i  in  1  memory accepts mem_req_o in the cycle both are high.
REQ-011 mem_rvalid_i / mem_rdata_i  in  1 / 32  memory response; one per granted request, reads and writes.
REQ-012 err_o  out  1  sticky protocol/timeout error.

Function
REQ-013 SHALL hold one pending slot per port; a req_i pulse with a free slot SHALL be captured at that clock edge.
REQ-014 SHALL ignore a req_i while that port's slot is occupied and SHALL set err_o.
REQ-015 SHALL run FSM IDLE -> ISSUE -> WAIT_RESP -> IDLE; IDLE->ISSUE when any slot is occupied; ISSUE->WAIT_RESP on mem_req_o && mem_gnt_i; WAIT_RESP->IDLE on mem_rvalid_i.
REQ-016 SHALL arbitrate in IDLE: a single occupied slot wins; if both are occupied, the port not granted last wins; the first tie after reset goes to data.
REQ-017 SHALL drive mem_* outputs from registers, stable throughout ISSUE; mem_req_o high only in ISSUE.
REQ-018 For instr grants, mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0; for data grants, the captured we/be/addr/wdata pass unchanged; addresses are not realigned.
REQ-019 SHALL free the owning slot in the cycle mem_rvalid_i is seen and pulse the owner's rvalid_o for exactly one cycle on the next edge.
REQ-020 rdata_o SHALL update only on a read response to that port and hold its value otherwise; a write response pulses data_rvalid_o without changing data_rdata_o.
REQ-021 Minimum latency, req_i at edge N: mem_req_o at N+1; with gnt at N+1 and mem_rvalid_i at N+2, rvalid_o is high after edge N+3.
REQ-022 SHALL accept a new req_i on a port in the same cycle its rvalid_o is high.
REQ-023 SHALL ignore mem_rvalid_i outside WAIT_RESP and SHALL set err_o.
REQ-024 SHALL set err_o and return to IDLE without a response pulse if ISSUE or WAIT_RESP persists for MEM_TIMEOUT cycles, dropping the owning slot.

Reset
REQ-025 On arstn_i low, SHALL immediately clear all outputs to 0, clear both slots, set FSM to IDLE, set last-grant to instr and clear err_o.
REQ-026 A reset mid-transaction SHALL drop the transaction without any response pulse.

Structure
REQ-027 Package miriscv_mem_arb_pkg SHALL hold the FSM state enum, the port-id enum (PORT_INSTR, PORT_DATA) and the request struct (we, be, addr, wdata).
REQ-028 Sub-module miriscv_mem_arb_slot (one pending request register plus valid) SHALL be instantiated once per port.

Verification
REQ-029 Single fetch: instr_req_i for addr 0x10, memory with gnt always 1 and 1-cycle response returning 0x00000013 -> one instr_rvalid_o pulse at N+3 with instr_rdata_o=0x00000013; data_rvalid_o stays 0.
REQ-030 Simultaneous requests: instr addr 0x0 and data read 0x40 in the same cycle -> data issued first, then instr; two mem transactions in that order.
REQ-031 Store: data_we_i=1, be=4'b0011, addr 0x44, wdata 0xDEADBEEF -> mem_be_o=4'b0011, mem_wdata_o=0xDEADBEEF; data_rvalid_o pulses and data_rdata_o is unchanged.
REQ-032 Back-pressure: mem_gnt_i low for 5 cycles -> mem_req_o and mem_addr_o held stable, grant in the 6th cycle, response delivered normally.
REQ-033 Protocol errors: a second instr_req_i before its response, or mem_rvalid_i in IDLE -> err_o=1 and sticky until reset.
REQ-034 Reset in WAIT_RESP: arstn_i low for 2 cycles -> outputs immediately 0, no rvalid_o pulse, next request is served normally.
